// File: rtl/soglia_detector.sv
// Latches a signed threshold and declares an event after MIN_LEN consecutive valid samples above it, then holds off for HOLDOFF valid samples.
// Outputs are registered one cycle after the deciding sample; there is no backpressure, and valid_in=0 cycles freeze all sample-driven state.
module soglia_detector #(
  parameter int MIN_LEN = 4,
  parameter int HOLDOFF = 8,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [11:0]      soglia,
  input  logic                    thr_load,
  input  logic                    valid_in,
  input  logic signed [11:0]      sample,
  input  logic                    cnt_clr,
  output logic                    detect,
  output logic                    peak_valid,
  output logic signed [11:0]      peak_out,
  output logic [CNT_W-1:0]        det_count,
  output logic                    busy
);

  localparam int RW = $clog2(MIN_LEN + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_EVENT, S_HOLD} state_t;

  state_t             state, state_nxt;
  logic signed [11:0] thr;
  logic signed [11:0] peak, peak_nxt;
  logic [RW-1:0]      run, run_nxt;
  logic [HW-1:0]      hold, hold_nxt;
  logic               detect_nxt, pv_nxt, above;

  // Uses the registered threshold, so a load only affects later samples.
  assign above = (sample > thr);

  always_comb begin
    state_nxt  = state;
    run_nxt    = run;
    peak_nxt   = peak;
    hold_nxt   = hold;
    detect_nxt = 1'b0;
    pv_nxt     = 1'b0;
    if (valid_in) begin
      case (state)
        S_IDLE: begin
          if (above) begin
            run_nxt  = RW'(1);
            peak_nxt = sample;
            if (MIN_LEN == 1) begin
              state_nxt  = S_EVENT;
              detect_nxt = 1'b1;
            end else begin
              state_nxt = S_ARM;
            end
          end
        end
        S_ARM: begin
          if (above) begin
            run_nxt = run + 1'b1;
            if (sample > peak) peak_nxt = sample;
            if (run_nxt == RW'(MIN_LEN)) begin
              state_nxt  = S_EVENT;
              detect_nxt = 1'b1;
            end
          end else begin
            run_nxt   = '0;
            state_nxt = S_IDLE;
          end
        end
        S_EVENT: begin
          if (above) begin
            if (sample > peak) peak_nxt = sample;
          end else begin
            pv_nxt  = 1'b1;
            run_nxt = '0;
            if (HOLDOFF == 0) begin
              state_nxt = S_IDLE;
            end else begin
              hold_nxt  = HW'(HOLDOFF);
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (hold <= HW'(1)) begin
            hold_nxt  = '0;
            state_nxt = S_IDLE;
          end else begin
            hold_nxt = hold - 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      thr        <= 12'sh7FF;
      run        <= '0;
      peak       <= '0;
      hold       <= '0;
      detect     <= 1'b0;
      peak_valid <= 1'b0;
      peak_out   <= '0;
      det_count  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      peak       <= peak_nxt;
      hold       <= hold_nxt;
      detect     <= detect_nxt;
      peak_valid <= pv_nxt;
      busy       <= (state_nxt != S_IDLE);
      if (thr_load) thr <= soglia;
      if (pv_nxt) peak_out <= peak;
      // A clear coinciding with a new detection leaves that detection counted.
      if (cnt_clr)
        det_count <= detect_nxt ? CNT_W'(1) : '0;
      else if (detect_nxt && (det_count != {CNT_W{1'b1}}))
        det_count <= det_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_soglia_detector.sv
// Directed bench for soglia_detector: default instance plus a MIN_LEN=1, HOLDOFF=0, CNT_W=2 instance.
module tb_soglia_detector;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [11:0] ld_sr = '0;
  logic               thr_load = 1'b0;
  logic               valid_in = 1'b0;
  logic               valid2 = 1'b0;
  logic signed [11:0] sample = '0;
  logic               cnt_clr = 1'b0;
  logic               clr2 = 1'b0;

  logic               detect, peak_valid, busy;
  logic signed [11:0] peak_out;
  logic [15:0]        det_count;
  logic               d2, pv2, busy2;
  logic signed [11:0] po2;
  logic [1:0]         cnt2;

  int n_assert = 0;
  int n_fail   = 0;

  soglia_detector u_dut (
    .clk(clk), .rst(rst), .soglia(ld_sr), .thr_load(thr_load),
    .valid_in(valid_in), .sample(sample), .cnt_clr(cnt_clr),
    .detect(detect), .peak_valid(peak_valid), .peak_out(peak_out),
    .det_count(det_count), .busy(busy)
  );

  soglia_detector #(.MIN_LEN(1), .HOLDOFF(0), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .soglia(ld_sr), .thr_load(thr_load),
    .valid_in(valid2), .sample(sample), .cnt_clr(clr2),
    .detect(d2), .peak_valid(pv2), .peak_out(po2),
    .det_count(cnt2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic signed [11:0] s,
                      input logic ld = 1'b0, input logic clr = 1'b0);
    valid_in = v;
    sample   = s;
    thr_load = ld;
    cnt_clr  = clr;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    thr_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  task automatic step2(input logic signed [11:0] s);
    valid2 = 1'b1;
    sample = s;
    @(posedge clk);
    #1;
    valid2 = 1'b0;
  endtask

  // Models the upstream serial-to-parallel loader, MSB first.
  task automatic shift_in(input logic [11:0] val);
    for (int i = 11; i >= 0; i--) begin
      ld_sr = {ld_sr[10:0], val[i]};
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 12'sd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_detect", detect, 0);
    chk("rst_pv", peak_valid, 0);
    chk("rst_peak", peak_out, 0);
    chk("rst_count", det_count, 0);
    chk("rst_busy", busy, 0);

    // Unloaded threshold of 2047 cannot be exceeded.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 12'sd2047);
      chk("t1_detect", detect, 0);
    end
    chk("t1_count", det_count, 0);
    chk("t1_busy", busy, 0);

    shift_in(12'b011001011101);
    step(1'b0, 12'sd0, 1'b1);
    step(1'b1, 12'sd1630);
    chk("t2_busy", busy, 1);
    step(1'b1, 12'sd1700);
    step(1'b1, 12'sd1650);
    chk("t2_early", detect, 0);
    step(1'b1, 12'sd1640);
    chk("t2_detect", detect, 1);
    chk("t2_count", det_count, 1);
    step(1'b1, 12'sd1600);
    chk("t2_pv", peak_valid, 1);
    chk("t2_peak", peak_out, 1700);
    chk("t2_detect_off", detect, 0);

    // Holdoff with invalid gaps in the middle.
    for (int i = 0; i < 4; i++) step(1'b1, 12'sd2000);
    for (int i = 0; i < 3; i++) step(1'b0, 12'sd2000);
    chk("t4_busy_gap", busy, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 12'sd2000);
    chk("t4_busy_hold", busy, 1);
    chk("t4_no_detect", detect, 0);
    step(1'b1, 12'sd2000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'sd2000);
      chk("t4_arm", detect, 0);
    end
    step(1'b1, 12'sd2000);
    chk("t4_detect", detect, 1);
    chk("t4_count", det_count, 2);
    step(1'b1, 12'sd1600);
    chk("t4_peak", peak_out, 2000);
    drain(8);
    chk("t4_idle", busy, 0);

    step(1'b1, 12'sd1630);
    step(1'b1, 12'sd1631);
    step(1'b1, 12'sd1632);
    chk("t3_armed", busy, 1);
    step(1'b1, 12'sd1629);
    chk("t3_detect", detect, 0);
    chk("t3_idle", busy, 0);
    chk("t3_count", det_count, 2);

    shift_in(12'hFCE);
    step(1'b0, 12'sd0, 1'b1);
    step(1'b1, -12'sd40);
    step(1'b1, -12'sd45);
    step(1'b1, -12'sd30);
    chk("t5_early", detect, 0);
    step(1'b1, -12'sd49);
    chk("t5_detect", detect, 1);
    chk("t5_count", det_count, 3);
    step(1'b1, -12'sd60);
    chk("t5_pv", peak_valid, 1);
    chk("t5_peak", peak_out, -30);
    drain(8);
    for (int i = 0; i < 5; i++) step(1'b1, -12'sd50);
    chk("t5_eq_detect", detect, 0);
    chk("t5_eq_busy", busy, 0);

    // Sample arriving with a load is judged against the old threshold (-50).
    shift_in(12'd100);
    step(1'b1, 12'sd0, 1'b1);
    chk("ld_old_thr", busy, 1);
    step(1'b1, 12'sd50);
    chk("ld_new_thr", busy, 0);

    for (int i = 0; i < 3; i++) step(1'b1, 12'sd200);
    step(1'b1, 12'sd200, 1'b0, 1'b1);
    chk("clr_with_detect", detect, 1);
    chk("clr_with_count", det_count, 1);
    step(1'b1, 12'sd0);
    chk("clr_peak", peak_out, 200);
    drain(8);
    step(1'b0, 12'sd0, 1'b0, 1'b1);
    chk("clr_alone", det_count, 0);

    for (int e = 1; e <= 5; e++) begin
      step2(12'sd200);
      if (e == 1) chk("sat_detect", d2, 1);
      step2(12'sd0);
      if (e == 1) chk("sat_peak", po2, 200);
      if (e == 3) chk("sat_count3", cnt2, 3);
    end
    chk("sat_count5", cnt2, 3);
    chk("sat_busy", busy2, 0);

    for (int i = 0; i < 4; i++) step(1'b1, 12'sd200);
    step(1'b1, 12'sd300);
    chk("pre_rst_count", det_count, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #2;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", det_count, 0);
    chk("mid_rst_peak", peak_out, 0);
    chk("mid_rst_pv", peak_valid, 0);
    chk("mid_rst_detect", detect, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 12'sd0);
    chk("post_rst_pv", peak_valid, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'sd2000);
    chk("post_rst_thr", busy, 0);
    chk("post_rst_detect", detect, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/soglia_detector.md
# soglia_detector

Threshold detector for the detector front end, directly downstream of the serial-to-parallel threshold loader. It latches the signed 12-bit threshold produced by that loader, compares a stream of signed 12-bit samples against it, and declares an event when enough consecutive samples exceed it. It reports each event's peak, counts events with a saturating counter, and applies a hold-off window after each event.

## Interface
- MIN_LEN, 4: number of consecutive above-threshold valid samples needed to declare an event (≥1).
- HOLDOFF, 8: number of valid samples ignored after an event ends (≥0).
- CNT_W, 16: width of the event counter.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous and active-high.
- soglia  in  12 signed  threshold from the serial-to-parallel loader.
- thr_load  in  1  captures soglia into the internal threshold register.
- valid_in  in  1  sample qualifier.
- sample  in  12 signed  input sample.
- cnt_clr  in  1  synchronous clear of det_count.
- detect  out  1  one-cycle pulse when an event is declared.
- peak_valid  out  1  one-cycle pulse at the end of an event.
- peak_out  out  12 signed  peak of the last completed event.
- det_count  out  CNT_W  saturating event count.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
**Compare rule**
- above = (sample > thr); signed, strict.
- thr is the internal register, not the live soglia.

**Threshold register**
- Loaded from soglia on any cycle with thr_load=1.
- A sample presented in the same cycle as thr_load is compared against the old thr.
- A load during ARM, EVENT or HOLD does not abort the current state.

**Sample processing**
- Only cycles with valid_in=1 advance the FSM, run counter, peak and hold counters.
- Cycles with valid_in=0 hold all of them.

**FSM**
- IDLE: on a valid above sample, run=1 and peak=sample. If MIN_LEN=1, go to EVENT and pulse detect; otherwise go to ARM.
- ARM: on a valid above sample, increment run and peak=max(peak,sample). When run reaches MIN_LEN, go to EVENT and pulse detect. On a valid non-above sample, go to IDLE and clear run.
- EVENT: on a valid above sample, peak=max(peak,sample). On a valid non-above sample:
  - peak_out←peak and peak_valid pulses.
  - If HOLDOFF=0, go to IDLE; otherwise load hold=HOLDOFF and go to HOLD.
- HOLD: each valid sample decrements hold; sample values are ignored. When hold reaches 0 (after exactly HOLDOFF valid samples), go to IDLE. The next valid sample is then evaluated in IDLE.

**det_count**
- Increments on each detect and saturates at 2^CNT_W−1.
- cnt_clr alone sets it to 0.
- cnt_clr and detect in the same cycle gives 1.

**Reset**
- Reset asserted at any time, including mid-event, forces the reset values below immediately.
- No peak_valid is generated for an event aborted by reset.

## Timing
- Reset values: state IDLE, thr=12'sh7FF (nothing can exceed it), run=0, peak=0, detect=0, peak_valid=0, peak_out=0, det_count=0, busy=0.
- All outputs are registered.
- detect is high in the cycle after the edge that samples the MIN_LEN-th consecutive above sample.
- det_count reflects that event in the same cycle detect is high.
- peak_valid and the new peak_out appear in the cycle after the edge that samples the first non-above sample in EVENT.
- busy is high from the cycle after the first above sample until the cycle after the return to IDLE.
- A thr_load takes effect for samples in the following cycle and later.

## Test plan
1. After reset, no load; 10 valid samples of 2047 → detect never asserts, det_count=0, busy=0.
2. Shift 12'sb011001011101 (1629) MSB first through the loader, then pulse thr_load. Samples 1630, 1700, 1650, 1640, 1600 → detect one cycle after 1640, det_count=1, then peak_valid with peak_out=1700.
3. thr=1629; samples 1630, 1631, 1632, 1629 → no detect (1629 is not strictly above), state returns to IDLE, det_count unchanged.
4. Holdoff: after the event in scenario 2, 8 valid samples of 2000 → ignored, busy stays high. Next 4 samples of 2000 → detect again, det_count=2. Also check that gaps with valid_in=0 do not shorten the holdoff.
5. thr loaded as −50; samples −40, −45, −30, −49 → detect. Then −60 → peak_out=−30. Separately, samples of −50 → no detect.
6. Boundaries:
   - CNT_W=2: 5 events → det_count=3.
   - cnt_clr together with detect → det_count=1.
   - rst asserted in EVENT → all outputs at reset values with no peak_valid; thr returns to 2047.
